apb_slave_regbank: RTL
======================

# apb_slave_regbank

Parametrised APB4 completer that terminates a bus segment in a bank of memory-mapped registers. It adds configurable data width, register count, programmable wait states, byte strobes (`pstrb`), `pready` flow control and `pslverr` error reporting. It sits behind the bus fabric and exposes the register contents to core logic. Read-only slots return values supplied by hardware.

## Interface
- `ADDR_WIDTH`, 32: width of `paddr`.
- `DATA_WIDTH`, 32: data width; legal values 8, 16, 32, 64.
- `NUM_REGS`, 16: number of registers, 1..256.
- `WAIT_STATES`, 0: `pready`-low cycles inserted in every access, 0..15.
- `RO_MASK`, 0: NUM_REGS-bit mask; bit i=1 makes register i read-only.
- `pclk  in  1`: bus clock; all logic on rising edge.
- `presetn  in  1`: asynchronous, active-low reset.
- `paddr  in  ADDR_WIDTH`: byte address.
- `psel  in  1`: select.
- `penable  in  1`: access phase.
- `pwrite  in  1`: 1 = write, 0 = read.
- `pwdata  in  DATA_WIDTH`: write data.
- `pstrb  in  DATA_WIDTH/8`: write byte lanes.
- `pprot  in  3`: protection attributes; only bit 0 (privileged) is used.
- `prdata  out  DATA_WIDTH`: read data.
- `pready  out  1`: transfer completes this cycle.
- `pslverr  out  1`: transfer error; valid only while `pready`=1.
- `reg_out  out  NUM_REGS*DATA_WIDTH`: flattened register contents; register i is at slice [i*DATA_WIDTH +: DATA_WIDTH].
- `ro_in  in  NUM_REGS*DATA_WIDTH`: hardware values returned for read-only slots.

## Operation
- **FSM states:** IDLE, SETUP, ACCESS.
  - IDLE -> SETUP on `psel`=1 and `penable`=0.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> IDLE when `pready`=1 and `psel`=0 at the next edge.
  - ACCESS -> SETUP when `pready`=1 and `psel`=1, `penable`=0 (back-to-back transfer).
  - ACCESS -> IDLE immediately if `psel` drops before completion (abort; no write).
- **Illegal entry:** `psel`=1 with `penable`=1 while in IDLE (no setup phase) is ignored. The FSM stays in IDLE and `pready` stays 0.
- **Wait counter:** 4 bits, loaded with `WAIT_STATES` on the SETUP edge. In ACCESS it decrements while nonzero. `pready` = (state==ACCESS && cnt==0).
- **Address decode:**
  - Index = `paddr` >> log2(DATA_WIDTH/8).
  - `paddr`, pwrite and pprot are captured on the SETUP edge and held internally for the whole access.
- **Error conditions** (evaluated on the captured values; any one sets `err`):
  - index ≥ NUM_REGS;
  - unaligned address (low log2(DATA_WIDTH/8) bits nonzero);
  - write to a read-only index;
  - write with `pprot[0]`=0 (unprivileged).
- **Write:** on the edge where `pready`=1, `pwrite`=1 and `err`=0, each byte lane b with `pstrb[b]`=1 is updated from `pwdata`. Lanes with `pstrb[b]`=0 keep their value. Errored writes change nothing.
- **Read:**
  - `prdata` = register value, or the `ro_in` slice for read-only indices, when `pready`=1, `pwrite`=0 and `err`=0.
  - Otherwise `prdata` is 0. Reads have no side effects.
  - Unprivileged reads are allowed.
- **`pslverr`** = `pready` & `err`; 0 at all other times.
- **`reg_out`:** reflects storage directly, with no extra delay. Read-only slices are tied to 0 (no storage implemented).

## Timing
- **Reset** (`presetn`=0, asynchronous): all registers 0, FSM to IDLE, counter 0. `pready`, `pslverr` and `prdata` are 0 combinationally. Reset during ACCESS aborts the transfer with no write. Operation resumes on the first rising edge after deassertion.
- **Cycle count:** a transfer occupies SETUP + (WAIT_STATES+1) ACCESS cycles, i.e. 2 cycles minimum with zero waits.
- **Write visibility:** a write is visible on `reg_out`, and to a following read, from the cycle after its completion edge.
- **Back-to-back:** transfers run with no idle cycle between them.
- **Output decode:** `prdata`, `pready` and `pslverr` are combinational from state, counter and captured address. They carry no further pipeline delay.

## Test plan
- **Zero-wait write/read:** WAIT_STATES=0, write 0xDEADBEEF to 0x08 with pstrb=0xF and pprot=3'b001 -> `pready`=1 in the 2nd cycle, `pslverr`=0. `reg_out` slice 2 = 0xDEADBEEF. Reading 0x08 returns 0xDEADBEEF.
- **Byte strobes:** register 2 holds 0xDEADBEEF; write 0x11223344 with pstrb=0x5 -> register reads 0xDE22BE44.
- **Wait states:** WAIT_STATES=3 -> `pready` low for exactly 3 ACCESS cycles, high on the 4th. Total transfer 5 cycles.
- **Error cases:** each of the following gives `pslverr`=1 with `pready`, no register changes, and `prdata`=0:
  - index 16 with NUM_REGS=16;
  - address 0x02;
  - write to a slot with its RO_MASK bit set;
  - write with `pprot[0]`=0.
  - A read of the RO slot returns its `ro_in` value with `pslverr`=0.
- **Back-to-back and abort:** a write followed immediately by a read of the same address returns the new data. `psel` dropped mid-wait-state -> FSM returns to IDLE and the register is unchanged.
- **Reset:** `presetn` asserted mid-ACCESS -> outputs 0 immediately. After release, all registers read 0 and a new transfer completes normally.

Source files
------------

// File: rtl/apb_slave_regbank.sv
// APB4 completer terminating a bus segment in a bank of memory-mapped registers.
// Supports byte strobes, programmable wait states, read-only HW slots and pslverr.
module apb_slave_regbank #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                           pclk,
  input  logic                           presetn,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  input  logic [2:0]                     pprot,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t r_state;
  state_t w_phase;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic                  r_prot0;
  logic [3:0]            r_cnt;

  logic [ADDR_WIDTH-1:0] w_full_idx;
  logic [IW-1:0]         w_idx;
  logic                  w_oob;
  logic                  w_unal;
  logic                  w_ro_hit;
  logic                  w_err;
  logic                  w_ready;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_rd_val;
  logic                  w_unused;

  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_ro   [NUM_REGS];

  assign w_unused = ^pprot[2:1];

  // SETUP is the bus setup-phase cycle; capture happens on its closing edge
  always_comb begin
    w_phase = r_state;
    if (r_state == S_IDLE && psel && !penable) begin
      w_phase = S_SETUP;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (w_phase)
      S_IDLE:   w_next = S_IDLE;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: begin
        if (!psel || w_ready) begin
          w_next = S_IDLE;
        end
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_prot0 <= 1'b0;
    end else if (w_phase == S_SETUP) begin
      r_addr  <= paddr;
      r_write <= pwrite;
      r_prot0 <= pprot[0];
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_cnt <= 4'd0;
    end else if (w_phase == S_SETUP) begin
      r_cnt <= 4'(WAIT_STATES);
    end else if (r_state == S_ACCESS && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign w_full_idx = r_addr >> LB;
  assign w_idx      = w_full_idx[IW-1:0];
  assign w_oob      = w_full_idx >= ADDR_WIDTH'(NUM_REGS);
  assign w_unal     = |(r_addr & ADDR_WIDTH'(NB - 1));
  assign w_ro_hit   = !w_oob && RO_MASK[w_idx];
  assign w_err      = w_oob | w_unal |
                      (r_write & (w_ro_hit | ~r_prot0));

  assign w_ready = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  assign w_wr_en = w_ready && psel && r_write && !w_err;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (RO_MASK[gi]) begin : g_ro
      assign w_regs[gi] = '0;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] r_q;
      always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
          r_q <= '0;
        end else if (w_wr_en && w_idx == IW'(gi)) begin
          for (int b = 0; b < NB; b++) begin
            if (pstrb[b]) begin
              r_q[b*8 +: 8] <= pwdata[b*8 +: 8];
            end
          end
        end
      end
      assign w_regs[gi] = r_q;
    end
    assign w_ro[gi] = ro_in[gi*DATA_WIDTH +: DATA_WIDTH];
    assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = w_regs[gi];
  end

  assign w_rd_val = w_ro_hit ? w_ro[w_idx] : w_regs[w_idx];

  assign pready  = w_ready;
  assign pslverr = w_ready & w_err;
  assign prdata  = (w_ready && !r_write && !w_err) ? w_rd_val : '0;

endmodule
